// File: rtl/d_latch_loader.sv
// Serial-to-parallel loader for a level-sensitive latch bank: one idle cycle of data
// setup before the enable pulse. Optional macro D_LATCH_LOADER_PARITY_EN adds an even-parity bit and perr_out.
module d_latch_loader #(
    parameter int WIDTH     = 8,
    parameter int EN_CYCLES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             sdata_in,
    input  logic             svalid_in,
    output logic             sready_out,
    output logic [WIDTH-1:0] d_out,
    output logic             en_out,
    output logic             done_out
`ifdef D_LATCH_LOADER_PARITY_EN
    ,
    output logic             perr_out
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [3:0] EN_LAST = 4'(EN_CYCLES - 1);
`ifdef D_LATCH_LOADER_PARITY_EN
    localparam logic [CW-1:0] PAR_IDX = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`endif

    typedef enum logic [2:0] {IDLE, SHIFT, SETUP, LOAD, DONE} state_t;

    state_t           r_state, w_state_next;
    logic [CW-1:0]    r_bit_cnt, w_bit_cnt_next;
    logic [WIDTH-1:0] r_shift, w_shift_next, w_shift_ins, w_sel;
    logic [WIDTH-1:0] r_d, w_d_next;
    logic [3:0]       r_en_cnt, w_en_cnt_next;
    logic             r_rdy, r_en, r_done, w_accept;
`ifdef D_LATCH_LOADER_PARITY_EN
    logic             r_perr, w_perr_next;
`endif

    // One-hot select of the shift-register slot addressed by the bit counter
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sel
            assign w_sel[gi] = (r_bit_cnt == CW'(gi));
        end
    endgenerate

    assign w_shift_ins = (r_shift & ~w_sel) | (w_sel & {WIDTH{sdata_in}});
    assign sready_out  = r_rdy && (r_state == IDLE || r_state == SHIFT);
    assign w_accept    = sready_out && svalid_in;

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_d_next       = r_d;
        w_en_cnt_next  = r_en_cnt;
`ifdef D_LATCH_LOADER_PARITY_EN
        w_perr_next    = r_perr;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_next   = {{(WIDTH-1){1'b0}}, sdata_in};
                    w_bit_cnt_next = CW'(1);
                    w_state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (w_accept) begin
`ifdef D_LATCH_LOADER_PARITY_EN
                    if (r_bit_cnt == PAR_IDX) begin
                        w_bit_cnt_next = '0;
                        if ((^r_shift) == sdata_in) begin
                            w_d_next     = r_shift;
                            w_state_next = SETUP;
                        end else begin
                            w_perr_next  = 1'b1;
                            w_state_next = DONE;
                        end
                    end else begin
                        w_shift_next   = w_shift_ins;
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
`else
                    w_shift_next = w_shift_ins;
                    if (r_bit_cnt == LAST_DATA) begin
                        w_bit_cnt_next = '0;
                        w_d_next       = w_shift_ins;
                        w_state_next   = SETUP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
`endif
                end
            end
            SETUP: begin
                w_en_cnt_next = '0;
                w_state_next  = LOAD;
            end
            LOAD: begin
                if (r_en_cnt == EN_LAST) begin
                    w_en_cnt_next = '0;
                    w_state_next  = DONE;
                end else begin
                    w_en_cnt_next = r_en_cnt + 1'b1;
                end
            end
            DONE: begin
                w_shift_next   = '0;
                w_bit_cnt_next = '0;
`ifdef D_LATCH_LOADER_PARITY_EN
                w_perr_next    = 1'b0;
`endif
                w_state_next   = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the latch enable never glitches
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_d       <= '0;
            r_en_cnt  <= '0;
            r_rdy     <= 1'b0;
            r_en      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_d       <= w_d_next;
            r_en_cnt  <= w_en_cnt_next;
            r_rdy     <= 1'b1;
            r_en      <= (w_state_next == LOAD);
`ifdef D_LATCH_LOADER_PARITY_EN
            r_done    <= (w_state_next == DONE) && !w_perr_next;
`else
            r_done    <= (w_state_next == DONE);
`endif
        end
    end

`ifdef D_LATCH_LOADER_PARITY_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr_next;
        end
    end

    assign perr_out = r_perr;
`endif

    assign d_out    = r_d;
    assign en_out   = r_en;
    assign done_out = r_done;

endmodule

// File: tb/tb_d_latch_loader.sv
// Self-checking bench for d_latch_loader: a timeline model predicts every output each cycle,
// plus directed literal checks on load timing, reset behaviour and (optionally) parity errors.
module tb_d_latch_loader;
    localparam int W  = 8;
    localparam int EN = 2;
`ifdef D_LATCH_LOADER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk_in    = 1'b0;
    logic         rst_n_in  = 1'b1;
    logic         sdata_in  = 1'b0;
    logic         svalid_in = 1'b0;
    logic         sready_out;
    logic [W-1:0] d_out;
    logic         en_out;
    logic         done_out;
`ifdef D_LATCH_LOADER_PARITY_EN
    logic         perr_out;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model state: frame end cycles drive the whole output timeline
    int           m_fe      = -1000;
    int           m_ce      = -1000;
    int           m_n       = 0;
    logic [W:0]   m_word    = '0;
    logic [W-1:0] m_latched = '0;
    logic [W-1:0] m_prev    = '0;
    bit           m_rdy     = 1'b0;

    int en_count   = 0;
    int en_first   = -1;
    int done_cyc   = -1;
    int done_count = 0;
    int perr_count = 0;
    int last_acc   = 0;
    int first_acc  = 0;

    d_latch_loader #(.WIDTH(W), .EN_CYCLES(EN)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .sdata_in   (sdata_in),
        .svalid_in  (svalid_in),
        .sready_out (sready_out),
        .d_out      (d_out),
        .en_out     (en_out),
        .done_out   (done_out)
`ifdef D_LATCH_LOADER_PARITY_EN
        ,
        .perr_out   (perr_out)
`endif
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    endtask

    always @(negedge clk_in) begin : cmp
        int c;
        bit busy, e_rdy, e_en, e_done, e_perr, ok;
        logic [W-1:0] e_d;
        c = cyc;
        if (!rst_n_in) begin
            m_fe = -1000; m_ce = -1000; m_n = 0; m_word = '0;
            m_latched = '0; m_prev = '0; m_rdy = 1'b0;
            chk("rst_d", 32'(d_out), 32'(0));
            chk("rst_en", 32'(en_out), 32'(0));
            chk("rst_done", 32'(done_out), 32'(0));
            chk("rst_ready", 32'(sready_out), 32'(0));
`ifdef D_LATCH_LOADER_PARITY_EN
            chk("rst_perr", 32'(perr_out), 32'(0));
`endif
        end else begin
            busy   = (c >= m_fe + 1 && c <= m_fe + 2 + EN) || (c == m_ce + 1);
            e_rdy  = m_rdy && !busy;
            e_en   = (c >= m_fe + 2) && (c <= m_fe + 1 + EN);
            e_done = (c == m_fe + 2 + EN);
            e_perr = (c == m_ce + 1);
            e_d    = (c >= m_fe + 1) ? m_latched : m_prev;
            chk("ready", 32'(sready_out), 32'(e_rdy));
            chk("en", 32'(en_out), 32'(e_en));
            chk("done", 32'(done_out), 32'(e_done));
            chk("d", 32'(d_out), 32'(e_d));
`ifdef D_LATCH_LOADER_PARITY_EN
            chk("perr", 32'(perr_out), 32'(e_perr));
            if (perr_out) perr_count++;
`endif
            if (en_out) begin
                en_count++;
                if (en_first < 0) en_first = c;
            end
            if (done_out) begin
                done_cyc = c;
                done_count++;
            end
            if (svalid_in && e_rdy) begin
                m_word[m_n] = sdata_in;
                m_n++;
                if (m_n == FL) begin
                    ok = 1'b1;
`ifdef D_LATCH_LOADER_PARITY_EN
                    ok = ((^m_word[W-1:0]) == m_word[W]);
`endif
                    if (ok) begin
                        m_prev    = e_d;
                        m_latched = m_word[W-1:0];
                        m_fe      = c;
                    end else begin
                        m_ce = c;
                    end
                    m_n    = 0;
                    m_word = '0;
                end
            end
            m_rdy = 1'b1;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        int k;
        svalid_in = 1'b1;
        sdata_in  = b;
        k = 0;
        @(negedge clk_in);
        while (!sready_out && k < 64) begin
            @(negedge clk_in);
            k++;
        end
        if (k >= 64) begin
            n_checks++;
            $display("FAIL accept_timeout: got sready 0 expected 1 within 64 cycles");
        end
        last_acc = cyc;
        @(posedge clk_in);
        #1;
        svalid_in = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap);
        for (int i = 0; i < W; i++) begin
            if (i > 0) wait_cycles(gap);
            send_bit(w[i]);
            if (i == 0) first_acc = last_acc;
        end
    endtask

    task automatic frame(input logic [W-1:0] w, input int gap);
        send_word(w, gap);
`ifdef D_LATCH_LOADER_PARITY_EN
        send_bit(^w);
`endif
    endtask

    task automatic clr_mon();
        en_count = 0;
        en_first = -1;
        done_cyc = -1;
    endtask

    initial begin
        int a5_c0, done0;
        #2 rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst_n_in = 1'b1;

        // Back-to-back words with svalid held high
        clr_mon();
        frame(8'hA5, 0);
        a5_c0 = first_acc;
        chk("a5_d_setup", 32'(d_out), 32'h0000_00A5);
        frame(8'h96, 0);
        chk("a5_en_count", 32'(en_count), 32'(2));
        chk("a5_en_start", 32'(en_first - a5_c0), 32'(FL + 1));
        chk("a5_done_at", 32'(done_cyc - a5_c0), 32'(FL + 3));
        chk("a5_next_first_bit", 32'(first_acc - a5_c0), 32'(FL + 4));
        chk("96_d_setup", 32'(d_out), 32'h0000_0096);
        wait_cycles(EN + 2);

        // Gaps of three idle cycles between bits
        clr_mon();
        frame(8'h3C, 3);
        chk("3c_d_setup", 32'(d_out), 32'h0000_003C);
        wait_cycles(EN + 2);
        chk("3c_en_count", 32'(en_count), 32'(2));

        // Toggling data offered while the block is busy must be dropped
        frame(8'h12, 0);
        for (int k = 0; k < EN + 2; k++) begin
            svalid_in = 1'b1;
            sdata_in  = k[0];
            @(posedge clk_in);
            #1;
        end
        svalid_in = 1'b0;
        frame(8'hFF, 0);
        chk("ff_d_setup", 32'(d_out), 32'h0000_00FF);
        wait_cycles(EN + 2);

        // Reset in the middle of LOAD
        frame(8'h5A, 0);
        @(posedge clk_in);
        #2;
        chk("5a_en_in_load", 32'(en_out), 32'(1));
        done0 = done_count;
        rst_n_in = 1'b0;
        #1;
        chk("5a_en_async_drop", 32'(en_out), 32'(0));
        chk("5a_d_cleared", 32'(d_out), 32'(0));
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        wait_cycles(EN + 3);
        chk("5a_no_done", 32'(done_count), 32'(done0));
        frame(8'h81, 0);
        chk("81_d_setup", 32'(d_out), 32'h0000_0081);
        wait_cycles(EN + 2);
        chk("81_done_seen", 32'(done_count), 32'(done0 + 1));

`ifdef D_LATCH_LOADER_PARITY_EN
        frame(8'h07, 0);
        chk("p07_good_d", 32'(d_out), 32'h0000_0007);
        wait_cycles(EN + 2);
        clr_mon();
        send_word(8'h07, 0);
        send_bit(1'b0);
        chk("p07_bad_d", 32'(d_out), 32'h0000_0007);
        send_word(8'h18, 0);
        send_bit(1'b1);
        chk("p18_bad_d", 32'(d_out), 32'h0000_0007);
        wait_cycles(3);
        chk("pbad_no_en", 32'(en_count), 32'(0));
        chk("pbad_perr_count", 32'(perr_count), 32'(2));
`endif

        wait_cycles(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400000");
        $fatal(1, "watchdog expired");
    end

endmodule
